data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter: m0 (core) and m1 (loader/debug) share one
// data bus controller. Round-robin grant, one transfer in flight, a busy
// timeout that aborts a stalled transfer, and fully registered outputs.
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [1:0]            m0_size,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [1:0]            m1_size,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  timeout_err,
  output logic                  owner,
  output logic                  bus_wd,
  output logic                  bus_rd,
  output logic [1:0]            bus_size,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  input  logic                  bus_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_prio_m1;
  logic                  r_owner;
  logic                  r_we;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wd;
  logic                  r_rd;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_terr;

  logic                  w_grant;
  logic                  w_pick_m1;
  logic                  w_sel_we;
  logic [1:0]            w_sel_size;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_timeout;

  // m1 wins only when it is the sole requester or it is its turn
  assign w_grant     = bus_ready & (m0_req | m1_req);
  assign w_pick_m1   = m1_req & (~m0_req | r_prio_m1);
  assign w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
  assign w_sel_size  = w_pick_m1 ? m1_size  : m0_size;
  assign w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Transfer sequencer: grant, strobe, wait for completion or timeout, ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_prio_m1 <= 1'b0;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wd      <= 1'b0;
      r_rd      <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata   <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_wd   <= 1'b0;
      r_rd   <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_pick_m1;
            r_prio_m1 <= ~w_pick_m1;
            r_we      <= w_sel_we;
            r_size    <= w_sel_size;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_wd      <= w_sel_we;
            r_rd      <= ~w_sel_we;
            r_cnt     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Ack is registered on the way into DONE so it is visible during DONE
          if (!bus_busy) begin
            r_rdata <= r_we ? '0 : bus_rdata;
            r_terr  <= 1'b0;
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_terr  <= 1'b1;
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_we    <= 1'b0;
          r_size  <= '0;
          r_addr  <= '0;
          r_wdata <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m0_ack      = r_ack0;
  assign m1_ack      = r_ack1;
  assign rdata       = r_rdata;
  assign timeout_err = r_terr;
  assign owner       = r_owner;
  assign bus_wd      = r_wd;
  assign bus_rd      = r_rd;
  assign bus_size    = r_size;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of grant order and completion.
module tb_data_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_ack;
  logic [1:0]    m0_size;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_ack;
  logic [1:0]    m1_size;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rdata;
  logic          timeout_err, owner, bus_wd, bus_rd;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          bus_ready, bus_busy;

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .timeout_err(timeout_err), .owner(owner),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_busy(bus_busy)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Pending master requests and scenario knobs
  bit            p_val [2];
  bit            p_drop[2];
  bit            p_we  [2];
  logic [1:0]    p_size[2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wd  [2];
  bit            s_rst = 1'b1;
  bit            s_ready = 1'b1;
  bit            rnd_drop = 1'b0;
  int            plan_n = -1;
  bit            force_rv = 1'b0;
  logic [DW-1:0] plan_rv = '0;

  // Transaction-level model
  int            cyc = 0;
  bit            m_busy = 1'b0;
  int            m_issue = 0, m_ack = 0, m_n = 0, m_idle_from = 0;
  bit            m_own = 1'b0, m_last = 1'b1, m_we = 1'b0, m_terr = 1'b0;
  logic [1:0]    m_size = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rval = '0, m_rdata = '0;
  bit            pv_r0 = 1'b0, pv_r1 = 1'b0, pv_ready = 1'b0, pv_idle = 1'b0, pv_rst = 1'b1;
  int            ack_cyc = -1, ack_m = 0, issue_cyc = -1;
  int            log_own[$];
  logic [AW-1:0] log_addr[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic post(input int m, input bit we, input logic [1:0] sz,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_val[m] = 1'b1; p_drop[m] = 1'b0; p_we[m] = we;
    p_size[m] = sz; p_addr[m] = a; p_wd[m] = d;
  endtask

  // Drive inputs sampled at the end of the current cycle
  task automatic apply();
    int k;
    rst = s_rst;
    m0_req = p_val[0] && !p_drop[0]; m0_we = p_we[0]; m0_size = p_size[0];
    m0_addr = p_addr[0]; m0_wdata = p_wd[0];
    m1_req = p_val[1] && !p_drop[1]; m1_we = p_we[1]; m1_size = p_size[1];
    m1_addr = p_addr[1]; m1_wdata = p_wd[1];
    bus_ready = s_ready;
    if (m_busy && cyc > m_issue && cyc < m_ack) begin
      k = cyc - m_issue - 1;
      bus_busy = (k < m_n);
      bus_rdata = bus_busy ? ~m_rval : m_rval;
    end else begin
      bus_busy = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end
    pv_r0 = m0_req; pv_r1 = m1_req; pv_ready = s_ready; pv_rst = s_rst;
  endtask

  // Compare the outputs of the current cycle against the model
  task automatic observe();
    bit       idle_now, w;
    bit [1:0] exp_strb, exp_ack;
    exp_strb = 2'b00; exp_ack = 2'b00;
    if (pv_rst) begin
      m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_rdata = '0; m_terr = 1'b0;
      m_idle_from = cyc;
    end else if (!m_busy && pv_idle && pv_ready && (pv_r0 || pv_r1)) begin
      w = (pv_r0 && pv_r1) ? !m_last : pv_r1;
      m_busy = 1'b1; m_own = w; m_last = w; m_issue = cyc;
      m_we = p_we[w]; m_size = p_size[w]; m_addr = p_addr[w]; m_wd = p_wd[w];
      m_n = (plan_n >= 0) ? plan_n : int'($urandom_range(0, TO + 2));
      m_rval = force_rv ? plan_rv : DW'($urandom);
      m_ack = cyc + 2 + ((m_n < TO) ? m_n : TO - 1);
      exp_strb = m_we ? 2'b10 : 2'b01;
      log_own.push_back(int'(w)); log_addr.push_back(m_addr);
      issue_cyc = cyc;
      chk("issue_addr", bus_addr, m_addr);
      chk("issue_size", bus_size, m_size);
      chk("issue_wdata", bus_wdata, m_wd);
    end else if (m_busy && cyc == m_ack) begin
      exp_ack = m_own ? 2'b10 : 2'b01;
      m_terr = (m_n >= TO);
      m_rdata = (m_we || m_terr) ? '0 : m_rval;
      m_busy = 1'b0; m_idle_from = cyc + 1;
      ack_cyc = cyc; ack_m = int'(m_own);
      p_val[m_own] = 1'b0; p_drop[m_own] = 1'b0;
    end else if (m_busy && cyc > m_issue) begin
      chk("hold_addr", bus_addr, m_addr);
      chk("hold_size", bus_size, m_size);
      chk("hold_wdata", bus_wdata, m_wd);
    end
    idle_now = !m_busy && (cyc >= m_idle_from);
    if (idle_now) begin
      chk("idle_addr", bus_addr, '0);
      chk("idle_size", bus_size, '0);
      chk("idle_wdata", bus_wdata, '0);
    end
    chk("strobe", {bus_wd, bus_rd}, exp_strb);
    chk("ack", {m1_ack, m0_ack}, exp_ack);
    chk("owner", owner, m_own);
    chk("rdata", rdata, m_rdata);
    chk("timeout_err", timeout_err, m_terr);
    pv_idle = idle_now;
    if (rnd_drop && m_busy && $urandom_range(0, 3) == 0) p_drop[m_own] = 1'b1;
  endtask

  task automatic tick();
    apply();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic wait_ack(input int limit);
    int t;
    t = 0;
    ack_cyc = -1;
    while (ack_cyc < 0 && t < limit) begin
      tick();
      t++;
    end
    chk("ack_arrived", ack_cyc >= 0, 1);
  endtask

  task automatic do_reset();
    p_val[0] = 1'b0; p_val[1] = 1'b0; p_drop[0] = 1'b0; p_drop[1] = 1'b0;
    s_rst = 1'b1;
    tick(); tick();
    s_rst = 1'b0;
    log_own.delete(); log_addr.delete();
  endtask

  initial begin
    int pc, t;
    for (int m = 0; m < 2; m++) begin
      p_val[m] = 0; p_drop[m] = 0; p_we[m] = 0; p_size[m] = '0; p_addr[m] = '0; p_wd[m] = '0;
    end
    do_reset();

    // Core read with minimum latency
    s_ready = 1'b1; plan_n = 0; force_rv = 1'b1; plan_rv = 32'hDEADBEEF;
    post(0, 1'b0, 2'b10, 32'h100, '0);
    pc = cyc;
    wait_ack(20);
    chk("rd_latency", ack_cyc - pc, 3);
    chk("rd_data", rdata, 32'hDEADBEEF);
    chk("rd_terr", timeout_err, 0);
    force_rv = 1'b0;

    // Simultaneous writes after reset: m0 first, then m1
    do_reset();
    post(0, 1'b1, 2'b10, 32'h4, 32'h11);
    post(1, 1'b1, 2'b10, 32'h8, 32'h22);
    wait_ack(20);
    chk("sim_first_m", ack_m, 0);
    wait_ack(20);
    chk("sim_second_m", ack_m, 1);
    chk("sim_log_n", log_own.size(), 2);
    if (log_own.size() >= 2) begin
      chk("sim_own0", log_own[0], 0);
      chk("sim_addr0", log_addr[0], 32'h4);
      chk("sim_own1", log_own[1], 1);
      chk("sim_addr1", log_addr[1], 32'h8);
    end

    // Fairness with both masters re-requesting immediately
    do_reset();
    plan_n = -1;
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p_val[m]) post(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      wait_ack(40);
    end
    chk("fair_log_n", log_own.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < log_own.size()) chk("fair_order", log_own[i], i % 2);
    p_val[0] = 1'b0; p_val[1] = 1'b0;
    tick();
    if (m_busy) wait_ack(40);

    // Timeout on m1 read, then a normal transfer
    do_reset();
    plan_n = TO + 4;
    post(1, 1'b0, 2'b10, 32'h40, '0);
    wait_ack(60);
    chk("to_latency", ack_cyc - issue_cyc, TO + 1);
    chk("to_terr", timeout_err, 1);
    chk("to_rdata", rdata, 0);
    plan_n = 1;
    post(1, 1'b0, 2'b01, 32'h44, '0);
    wait_ack(20);
    chk("after_to_terr", timeout_err, 0);

    // Bus not ready blocks the grant
    do_reset();
    s_ready = 1'b0; plan_n = 0;
    post(0, 1'b0, 2'b00, 32'h10, '0);
    repeat (5) tick();
    chk("nready_no_grant", log_own.size(), 0);
    s_ready = 1'b1;
    pc = cyc;
    wait_ack(20);
    chk("ready_grant_cyc", issue_cyc - pc, 1);

    // Reset in the middle of WAIT
    do_reset();
    plan_n = TO + 4;
    post(0, 1'b0, 2'b10, 32'h200, '0);
    issue_cyc = -1; t = 0;
    while (issue_cyc < 0 && t < 20) begin tick(); t++; end
    chk("rst_issue_seen", issue_cyc >= 0, 1);
    tick(); tick();
    p_val[0] = 1'b0; p_val[1] = 1'b0;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("rst_addr", bus_addr, 0);
    ack_cyc = -1;
    repeat (5) tick();
    chk("rst_no_ack", ack_cyc, -1);
    plan_n = 0;
    post(1, 1'b1, 2'b10, 32'h300, 32'h5A);
    wait_ack(20);
    chk("rst_then_m1", ack_m, 1);

    // Random traffic
    do_reset();
    plan_n = -1; rnd_drop = 1'b1;
    repeat (600) begin
      for (int m = 0; m < 2; m++)
        if (!p_val[m] && $urandom_range(0, 2) == 0)
          post(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      s_ready = ($urandom_range(0, 4) != 0);
      tick();
    end
    rnd_drop = 1'b0;
    p_val[0] = 1'b0; p_val[1] = 1'b0; s_ready = 1'b1;
    t = 0;
    while (m_busy && t < 40) begin tick(); t++; end
    chk("drain", m_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
